// File: rtl/axis_pin_packetizer.sv
// Pin-bus to AXI4-Stream packetizer: LSB-first lane packing, TLAST framing, TKEEP flush, drop-on-full.
// Latency: final-lane sample at edge k -> word valid after edge k+1. Backpressure: sampling never
// stalls, words completing into a full FIFO are dropped and counted. Test pattern: AXIS_PIN_PACKETIZER_TESTPAT_EN.

module axis_pin_packetizer_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic                  wr_rdy,
  output logic                  rd_vld,
  output logic [WIDTH-1:0]      rd_dat,
  input  logic                  rd_rdy,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop;

  assign pop    = !empty && rd_rdy;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_rdy = !full || rd_rdy;
  assign push   = wr_vld && wr_rdy;
  assign rd_vld = !empty;
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          level <= level + 1'b1;
          full  <= (level == LVL_FULL - LVL_ONE);
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - 1'b1;
          full  <= 1'b0;
          empty <= (level == LVL_ONE);
        end
        default: ;
      endcase
    end
  end
endmodule

module axis_pin_packetizer #(
  parameter int PIN_WIDTH       = 8,
  parameter int TDATA_WIDTH     = 32,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PKT_LEN_WIDTH   = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [PIN_WIDTH-1:0]       data_pins,
  input  logic                       pin_valid,
  input  logic                       enable,
  input  logic [PKT_LEN_WIDTH-1:0]   pkt_len,
  input  logic                       test_mode,
  input  logic                       overflow_clr,
  output logic                       input_ready,
  output logic                       fifo_full_flag,
  output logic                       fifo_empty_flag,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]                overflow_count,
  output logic                       m_axis_tvalid,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [1:0]                 m_axis_tdest,
  output logic [7:0]                 m_axis_tid,
  input  logic                       m_axis_tready
);
  localparam int LANES      = TDATA_WIDTH / PIN_WIDTH;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int KEEP_W     = TDATA_WIDTH / 8;
  localparam int LANE_BYTES = PIN_WIDTH / 8;
  localparam int ENTRY_W    = 1 + KEEP_W + TDATA_WIDTH;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;

  logic [LANE_W-1:0]        lane_cnt;
  logic [TDATA_WIDTH-1:0]   asm_dat, asm_nxt, stage_dat;
  logic                     stage_vld;
  logic [PKT_LEN_WIDTH-1:0] word_cnt, word_cnt_nxt, len_q, len_eff;
  logic [PIN_WIDTH-1:0]     sample;
  logic                     capture, word_done, commit_ok, commit_last, drop, term_wr;
  logic                     fifo_wr_vld, fifo_wr_rdy;
  logic [ENTRY_W-1:0]       fifo_wr_dat, fifo_rd_dat;
  logic [KEEP_W-1:0]        term_keep;

  assign capture   = (state_q == RUN) && enable && pin_valid;
  assign word_done = capture && (lane_cnt == LANE_LAST);

`ifdef AXIS_PIN_PACKETIZER_TESTPAT_EN
  logic [PIN_WIDTH-1:0] tp_cnt;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                tp_cnt <= '0;
    else if (state_q != RUN && state_d == RUN)   tp_cnt <= '0;
    else if (capture)                            tp_cnt <= tp_cnt + 1'b1;
  end
  assign sample = test_mode ? tp_cnt : data_pins;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign sample = data_pins;
`endif

  always_comb begin
    asm_nxt   = asm_dat;
    term_keep = '0;
    for (int l = 0; l < LANES; l++) begin
      if (LANE_W'(l) == lane_cnt) asm_nxt[l*PIN_WIDTH +: PIN_WIDTH] = sample;
      if (LANE_W'(l) < lane_cnt)  term_keep[l*LANE_BYTES +: LANE_BYTES] = '1;
    end
  end

  // Completed words wait one cycle in the stage; accept/drop and framing are decided at FIFO write.
  assign len_eff     = (word_cnt == '0) ? pkt_len : len_q;
  assign commit_last = (len_eff != '0) && (PKT_LEN_WIDTH'(word_cnt + 1'b1) == len_eff);
  assign commit_ok   = stage_vld && fifo_wr_rdy;
  assign drop        = stage_vld && !fifo_wr_rdy;
  assign term_wr     = (state_q == FLUSH) && !fifo_full_flag;

  always_comb begin
    word_cnt_nxt = word_cnt;
    if (commit_ok) word_cnt_nxt = (len_eff == '0 || commit_last) ? '0 : word_cnt + 1'b1;
  end

  assign fifo_wr_vld = stage_vld || term_wr;
  assign fifo_wr_dat = term_wr ? {1'b1, term_keep, asm_dat}
                               : {commit_last, {KEEP_W{1'b1}}, stage_dat};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      // A word committing on this edge counts toward the open packet.
      RUN:   if (!enable) state_d = (word_cnt_nxt != '0 || (lane_cnt != '0 && pkt_len != '0))
                                    ? FLUSH : IDLE;
      FLUSH: if (!fifo_full_flag) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      lane_cnt       <= '0;
      asm_dat        <= '0;
      stage_vld      <= 1'b0;
      stage_dat      <= '0;
      word_cnt       <= '0;
      len_q          <= '0;
      overflow_count <= '0;
    end else begin
      state_q   <= state_d;
      stage_vld <= word_done;
      if (word_done) stage_dat <= asm_nxt;
      if (commit_ok && word_cnt == '0) len_q <= pkt_len;

      if (state_d == IDLE) begin
        lane_cnt <= '0;
        asm_dat  <= '0;
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt_nxt;
        if (word_done) begin
          lane_cnt <= '0;
          asm_dat  <= '0;
        end else if (capture) begin
          lane_cnt <= lane_cnt + 1'b1;
          asm_dat  <= asm_nxt;
        end
      end

      if (overflow_clr)                           overflow_count <= '0;
      else if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 1'b1;
    end
  end

  axis_pin_packetizer_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_vld  (fifo_wr_vld),
    .wr_dat  (fifo_wr_dat),
    .wr_rdy  (fifo_wr_rdy),
    .rd_vld  (m_axis_tvalid),
    .rd_dat  (fifo_rd_dat),
    .rd_rdy  (m_axis_tready),
    .full    (fifo_full_flag),
    .empty   (fifo_empty_flag),
    .level   (fifo_level)
  );

  assign input_ready  = !fifo_full_flag;
  assign m_axis_tdata = fifo_rd_dat[TDATA_WIDTH-1:0];
  assign m_axis_tkeep = fifo_rd_dat[TDATA_WIDTH +: KEEP_W];
  assign m_axis_tlast = fifo_rd_dat[ENTRY_W-1];
  assign m_axis_tstrb = m_axis_tkeep;
  assign m_axis_tdest = '0;
  assign m_axis_tid   = '0;
endmodule

// File: doc/axis_pin_packetizer.md
# axis_pin_packetizer

Parametrised successor to the byte-wide pin-to-AXI4-Stream source. It samples a `PIN_WIDTH` parallel pin bus under a strobe and packs `TDATA_WIDTH/PIN_WIDTH` samples LSB-first into each word. Words are buffered in a `2^FIFO_DEPTH_LOG2` FIFO and presented on an AXI4-Stream master feeding the PolarFire SoC DMA. It adds optional packet framing with TLAST, partial-word flush with TKEEP, a non-stalling drop policy with a saturating overflow counter, and a FIFO level output.

## Interface
- `PIN_WIDTH`, 8 — sample width; legal values 8, 16, 32.
- `TDATA_WIDTH`, 32 — stream width; an integer multiple of `PIN_WIDTH`, at most 128. `LANES = TDATA_WIDTH/PIN_WIDTH`.
- `FIFO_DEPTH_LOG2`, 4 — FIFO holds `2^FIFO_DEPTH_LOG2` words.
- `PKT_LEN_WIDTH`, 16 — width of `pkt_len`.
- `aclk` in 1 — single clock; all logic on its rising edge.
- `aresetn` in 1 — asynchronous, active-low reset.
- `data_pins` in `PIN_WIDTH` — sample bus.
- `pin_valid` in 1 — sample strobe; `data_pins` is taken on cycles where `pin_valid=1`.
- `enable` in 1 — capture enable.
- `pkt_len` in `PKT_LEN_WIDTH` — words per packet; 0 selects continuous mode (TLAST never asserted).
- `test_mode` in 1 — replace pin data with the test pattern (see Configuration).
- `overflow_clr` in 1 — synchronous clear of `overflow_count`.
- `input_ready` out 1 — equals `!fifo_full_flag`.
- `fifo_full_flag` out 1 — FIFO full.
- `fifo_empty_flag` out 1 — FIFO empty.
- `fifo_level` out `FIFO_DEPTH_LOG2+1` — words currently stored.
- `overflow_count` out 16 — saturating count of dropped words.
- `m_axis_tvalid` out 1 — AXI4-Stream TVALID.
- `m_axis_tdata` out `TDATA_WIDTH` — AXI4-Stream TDATA.
- `m_axis_tlast` out 1 — AXI4-Stream TLAST.
- `m_axis_tkeep` out `TDATA_WIDTH/8` — AXI4-Stream TKEEP.
- `m_axis_tstrb` out `TDATA_WIDTH/8` — always equals `m_axis_tkeep`.
- `m_axis_tdest` out 2 — tied to 0.
- `m_axis_tid` out 8 — tied to 0.
- `m_axis_tready` in 1 — AXI4-Stream TREADY.

## Operation
- **State machine.**
  - `IDLE`: entered from reset. Moves to `RUN` when `enable=1`.
  - `RUN`: moves to `IDLE` or `FLUSH` when `enable=0` (rules below).
  - `FLUSH`: moves to `IDLE` after the terminator word is written.
- **Entering `RUN`.** Lane counter cleared, word counter cleared.
- **Sample capture in `RUN`.**
  - Each `pin_valid` sample fills lane `lane_cnt`; lane 0 occupies the LSBs.
  - On lane `LANES-1`, the completed word (`tkeep` all ones) is written to the FIFO and `lane_cnt` returns to 0.
- **Packet framing.**
  - `pkt_len` is latched when `word_cnt==0` and a word is accepted.
  - TLAST is set on the accepted word where `word_cnt == latched_len-1`; `word_cnt` then returns to 0.
- **Drop policy.**
  - A word that completes while the FIFO is full is dropped.
  - On a drop, `overflow_count` increments, saturating at `0xFFFF`, and `word_cnt` does not advance.
  - Sampling never stalls.
- **`enable` falling in `RUN`.**
  - Continuous mode, or `lane_cnt==0 && word_cnt==0`: go to `IDLE`; any partial word is discarded.
  - Packet mode with `lane_cnt>0` or `word_cnt>0`: go to `FLUSH`.
- **`FLUSH`.**
  - Waits until the FIFO is not full, then writes one terminator and goes to `IDLE`.
  - Terminator contents: the partial word, unfilled lanes zero; `tkeep` ones only for filled lanes' bytes (all zero if `lane_cnt==0`); TLAST=1.
  - Samples are ignored while in `FLUSH`.
- **FIFO.**
  - Each entry stores {tlast, tkeep, tdata}.
  - Pointers wrap at `2^FIFO_DEPTH_LOG2`.
  - A simultaneous write and read leaves `fifo_level` unchanged. A write in the same cycle as a read of a full FIFO is accepted.
- **AXI output.**
  - `m_axis_tvalid = !empty`.
  - Data, tlast and tkeep come from the head entry; a pop occurs on `tvalid && tready`.
  - Head contents stay stable while `tvalid && !tready`.
- **Overflow counter.** `overflow_clr` has priority over a same-cycle increment, i.e. the counter reads 0 next cycle.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata` = 0.
  - `m_axis_tkeep`, `m_axis_tstrb` = 0.
  - `fifo_empty_flag` = 1, `fifo_full_flag` = 0, `input_ready` = 1.
  - `fifo_level` = 0, `overflow_count` = 0.
  - State `IDLE`; all counters 0.
- Latency: the final-lane sample is taken at edge k; the word is visible with `tvalid=1` after edge k+1.
- `enable` is sampled per cycle; samples take effect from the first cycle in `RUN`.
- `fifo_level`, `fifo_full_flag`, `fifo_empty_flag` and `overflow_count` are registered and update one edge after the event.
- Asserting `aresetn` low at any point clears state immediately. FIFO contents are lost, no terminator is emitted, and all outputs take their reset values.

## Configuration
- `AXIS_PIN_PACKETIZER_TESTPAT_EN`
- **Defined:**
  - With `test_mode=1`, each accepted sample is an internal `PIN_WIDTH` counter in place of `data_pins`.
  - The counter starts at 0 on reset and on each entry to `RUN`, and increments per accepted sample, wrapping.
- **Undefined:** `test_mode` is ignored and the counter logic is absent.

## Test plan
- Defaults, `pkt_len=0`, `tready=1`, 8 strobes 0x01..0x08 → tdata 0x04030201 then 0x08070605; tlast=0; tkeep=0xF.
- `pkt_len=3`, 12 words → tlast on words 3, 6, 9, 12 only.
- `tready=0`, 20 words → 16 stored; `overflow_count=4`; `fifo_full_flag=1`; `tready=1` then drains the first 16 words in order.
- `pkt_len=4`, disable after 5 words + 2 samples → word 6 has tkeep=0x3, tlast=1, lanes 2–3 zero; state `IDLE`.
- Simultaneous push and pop at `fifo_level=16`, then `aresetn` pulsed low mid-packet → level stays 16; after reset `tvalid=0`, `fifo_level=0`.
- Test pattern built in, `test_mode=1`, 8 strobes → tdata 0x03020100 then 0x07060504.
